// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a sync FIFO, absorbs its read latency in a 3-entry buffer
// and presents the words as a valid/ready stream framed into PKT_LEN-word packets.
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic [15:0]      pkt_cnt
);
    localparam int IW = $clog2(PKT_LEN);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [3];
    logic [1:0]       wr_ptr, rd_ptr, buf_cnt;
    logic             rd_pend, hs, idx_wrap;
    logic [IW-1:0]    word_idx;
    assign busy     = state != IDLE;
    assign m_valid  = buf_cnt != 2'd0;
    assign m_data   = m_valid ? mem[rd_ptr] : '0;
    assign idx_wrap = word_idx == IW'(PKT_LEN - 1);
    assign m_last   = m_valid && idx_wrap;
    assign hs       = m_valid && m_ready;
    // a pop is only issued when the word already in flight still has a free slot
    assign fifo_rd  = rst_n && state == RUN && en && !fifo_empty
                      && (3'(buf_cnt) + 3'(rd_pend) < 3'd3);
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = en ? RUN : IDLE;
            RUN:     state_nxt = en ? RUN : DRAIN;
            DRAIN:   state_nxt = (!rd_pend && buf_cnt == 2'd0) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_pend  <= 1'b0;
            buf_cnt  <= 2'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            word_idx <= '0;
            pkt_cnt  <= 16'd0;
        end else begin
            state   <= state_nxt;
            rd_pend <= fifo_rd && !fifo_empty;
            buf_cnt <= buf_cnt + 2'(rd_pend) - 2'(hs);
            if (rd_pend)
                wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
            if (hs) begin
                rd_ptr   <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
                word_idx <= idx_wrap ? '0 : word_idx + IW'(1);
                if (idx_wrap)
                    pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && rd_pend)
            mem[wr_ptr] <= fifo_data;
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: queue-based FIFO model plus stream scoreboard around fifo_stream_reader.
module tb_fifo_stream_reader;
    localparam int W = 8;
    localparam int L = 16;
    logic         clk = 0, rst_n = 0, en = 0, fifo_empty = 1, m_ready = 0;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd, m_valid, m_last, busy;
    logic [W-1:0] m_data;
    logic [15:0]  pkt_cnt;
    int           checks = 0, passed = 0;
    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    int           hs_cyc[$], pop_cyc[$];
    int           cyc = 0, words_out = 0, pops = 0;
    logic [15:0]  exp_pkt = 0;
    bit           acc_prev = 0, rst_prev = 0, hold_v = 0, hold_l = 0;
    logic [W-1:0] hold_d = '0;

    fifo_stream_reader #(.WIDTH(W), .PKT_LEN(L)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: update the FIFO model, sample at mid-cycle, return just after the edge.
    task automatic step();
        @(negedge clk);
        if (acc_prev) fifo_data = src_q.pop_front();
        fifo_empty = src_q.size() == 0;
        #1;
        cyc++;
        if (!rst_n) begin
            check("rst_rd", fifo_rd, 0);
            if (rst_prev) begin
                check("rst_valid", m_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_pkt", pkt_cnt, 0);
                check("rst_last", m_last, 0);
                check("rst_data", m_data, 0);
            end
            exp_q.delete(); hs_cyc.delete(); pop_cyc.delete();
            words_out = 0; pops = 0; exp_pkt = 0; hold_v = 0; acc_prev = 0;
        end else begin
            check("pkt_cnt", pkt_cnt, exp_pkt);
            if (hold_v) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_d);
                check("hold_last", m_last, hold_l);
            end
            if (!m_valid) check("last_idle", m_last, 0);
            if (!en) check("rd_off", fifo_rd, 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("spurious", m_valid, 0);
                else check("data", m_data, exp_q.pop_front());
                check("last", m_last, words_out % L == L - 1);
                words_out++;
                hs_cyc.push_back(cyc);
                if (words_out % L == 0) exp_pkt++;
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            acc_prev = fifo_rd && !fifo_empty;
            if (acc_prev) begin
                exp_q.push_back(src_q[0]);
                pops++;
                pop_cyc.push_back(cyc);
                check("occupancy", pops - words_out <= 3, 1);
            end
        end
        rst_prev = !rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        en = 0;
        m_ready = 1;
        for (int i = 0; i < 30 && (busy || m_valid); i++) step();
        check("drain_idle", busy, 0);
    endtask

    initial begin
        int p0, w0, need;
        // reset held with en=1 and a non-empty FIFO
        rst_n = 0; en = 1; src_q.push_back(8'hEE);
        repeat (3) step();
        src_q.delete();
        rst_n = 1; en = 0;
        step();
        // full-rate packet
        for (int i = 0; i < 16; i++) src_q.push_back(W'(i));
        step();
        en = 1; m_ready = 1;
        for (int i = 0; i < 60 && words_out < 16; i++) step();
        check("tp_words", words_out, 16);
        check("tp_span", hs_cyc[15] - hs_cyc[0], 15);
        check("tp_lat", hs_cyc[0] - pop_cyc[0], 2);
        step();
        check("tp_pkt", pkt_cnt, 1);
        drain();
        // backpressure fills the buffer then releases
        for (int i = 0; i < 16; i++) src_q.push_back(8'h20 + W'(i));
        m_ready = 0; en = 1;
        repeat (8) step();
        check("bp_rd", fifo_rd, 0);
        check("bp_occ", pops - words_out, 3);
        check("bp_data", m_data, 8'h20);
        m_ready = 1;
        repeat (24) step();
        drain();
        // only three words available
        p0 = pops;
        for (int i = 0; i < 3; i++) src_q.push_back(8'h30 + W'(i));
        en = 1; m_ready = 1;
        repeat (10) step();
        check("empty_pops", pops - p0, 3);
        check("empty_valid", m_valid, 0);
        check("empty_rd", fifo_rd, 0);
        // stop with one pop in flight and two words buffered
        m_ready = 0;
        src_q.push_back(8'h40); src_q.push_back(8'h41);
        repeat (6) step();
        src_q.push_back(8'h42);
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc_prev) break;
        end
        check("drain_setup", pops - words_out, 3);
        en = 0; m_ready = 1;
        for (int i = 0; i < 4; i++) src_q.push_back(8'h50 + W'(i));
        w0 = words_out;
        step();
        en = 1;
        step();
        check("drain_rd", fifo_rd, 0);
        en = 0;
        step();
        check("drain_words", words_out - w0, 3);
        for (int i = 0; i < 2 && busy; i++) step();
        check("drain_busy", busy, 0);
        // randomized traffic with en toggling
        for (int i = 0; i < 60; i++) src_q.push_back(W'($urandom));
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 9) != 0;
            m_ready = $urandom_range(0, 3) != 0;
            if (src_q.size() < 4 && $urandom_range(0, 1) == 1) src_q.push_back(W'($urandom));
            step();
        end
        drain();
        // packet counter wrap
        force dut.pkt_cnt = 16'hFFFF;
        #1;
        release dut.pkt_cnt;
        exp_pkt = 16'hFFFF;
        need = L - words_out % L + 4;
        for (int i = 0; i < need; i++) src_q.push_back(W'($urandom));
        en = 1; m_ready = 1;
        for (int i = 0; i < 80 && exp_pkt != 0; i++) step();
        step();
        check("wrap", pkt_cnt, 16'h0000);
        drain();
        // reset in the middle of a packet
        for (int i = 0; i < 5; i++) src_q.push_back(8'h60 + W'(i));
        en = 1; m_ready = 1;
        repeat (4) step();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1; en = 0;
        repeat (2) step();
        check("post_rst_valid", m_valid, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
